key_event_ctrl: RTL

//   Debounces and sequences the raw push-button inputs of the gomoku board UI.

---
 rtl/key_event_ctrl.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/key_event_ctrl.sv
// key_event_ctrl: debounces raw push-buttons, turns stable presses into key events and queues them for the game core.
// Latency: key_in rise to evt_valid is DEBOUNCE_CYCLES+4 cycles when the queue is empty and no other key is pending.
// Backpressure: evt_ready low holds the head; new presses wait in pending[k], and a second press on a pending key is dropped and sets evt_overflow.
// Build option: define KEY_REPEAT_EN to add hold-to-repeat timers (REPEAT_DELAY, REPEAT_PERIOD, REPEAT_MASK).

module key_event_fifo #(
  parameter int W     = 3,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_rdy,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head_dat
);
  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic         push_ok, pop_ok;

  // Occupancy flags, accepted push/pop and next pointer/storage values.
  always_comb begin
    empty   = (wr_q == rd_q);
    full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    pop_ok  = pop_rdy && !empty;
    push_ok = push_vld && (!full || pop_ok);
    wr_d    = wr_q;
    rd_d    = rd_q;
    mem_d   = mem_q;
    if (push_ok) begin
      wr_d = wr_q + 1'b1;
      mem_d[wr_q[AW-1:0]] = push_dat;
    end
    if (pop_ok) begin
      rd_d = rd_q + 1'b1;
    end
    head_dat = mem_q[rd_q[AW-1:0]];
  end

  // Pointer and storage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end
endmodule

module key_event_ctrl #(
  parameter int          N_KEYS          = 5,
  parameter int          DEBOUNCE_CYCLES = 1000000,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          REPEAT_DELAY    = 50000000,
  parameter int          REPEAT_PERIOD   = 10000000,
  parameter logic [15:0] REPEAT_MASK     = 16'hF
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [N_KEYS-1:0]         key_in,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [$clog2(N_KEYS)-1:0] evt_code,
  output logic [N_KEYS-1:0]         key_state,
  output logic                      evt_overflow
);
  localparam int KW = $clog2(N_KEYS);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic [N_KEYS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [N_KEYS-1:0] stable_q, stable_d, prev_q, prev_d;
  logic [N_KEYS-1:0] pending_q, pending_d;
  logic [CW-1:0]     cnt_q [N_KEYS];
  logic [CW-1:0]     cnt_d [N_KEYS];
  logic [KW-1:0]     rr_q, rr_d;
  logic              ovf_q, ovf_d;

  logic [N_KEYS-1:0] press, rpt_hit, evt_raw, grant_oh;
  logic              grant_vld, fifo_full, fifo_empty, pop;
  logic [KW-1:0]     grant_idx, idx_w, head_code;
  int                idx;

  // Two-flop synchronizer and per-key debounce: a level is accepted only after
  // the synchronized input has disagreed with it for DEBOUNCE_CYCLES edges in a row.
  always_comb begin
    sync1_d  = key_in;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    prev_d   = stable_q;
    for (int k = 0; k < N_KEYS; k++) begin
      cnt_d[k] = cnt_q[k];
      if (sync2_q[k] == stable_q[k]) begin
        cnt_d[k] = '0;
      end else if (cnt_q[k] == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable_d[k] = sync2_q[k];
        cnt_d[k]    = '0;
      end else begin
        cnt_d[k] = cnt_q[k] + 1'b1;
      end
    end
  end

  assign press = stable_q & ~prev_q;

`ifdef KEY_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW      = $clog2(RPT_MAX + 1);

  // phase_q=0 waits for the first repeat (REPEAT_DELAY), phase_q=1 for later ones (REPEAT_PERIOD).
  logic [HW-1:0]     hold_q [N_KEYS];
  logic [HW-1:0]     hold_d [N_KEYS];
  logic [N_KEYS-1:0] phase_q, phase_d;

  // Hold timers: count edges while the debounced level is high, fire and restart on each repeat.
  always_comb begin
    phase_d = phase_q;
    rpt_hit = '0;
    for (int k = 0; k < N_KEYS; k++) begin
      hold_d[k]  = hold_q[k];
      rpt_hit[k] = REPEAT_MASK[k] && stable_q[k] &&
                   (phase_q[k] ? (hold_q[k] == HW'(REPEAT_PERIOD))
                               : (hold_q[k] == HW'(REPEAT_DELAY)));
      if (!stable_q[k] || !REPEAT_MASK[k]) begin
        hold_d[k]  = '0;
        phase_d[k] = 1'b0;
      end else if (rpt_hit[k]) begin
        hold_d[k]  = HW'(1);
        phase_d[k] = 1'b1;
      end else begin
        hold_d[k] = hold_q[k] + 1'b1;
      end
    end
  end

  // Hold timer registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      phase_q <= '0;
      for (int k = 0; k < N_KEYS; k++) begin
        hold_q[k] <= '0;
      end
    end else begin
      phase_q <= phase_d;
      hold_q  <= hold_d;
    end
  end
`else
  logic unused_repeat_cfg;
  assign rpt_hit           = '0;
  assign unused_repeat_cfg = ^{REPEAT_MASK, REPEAT_DELAY[0], REPEAT_PERIOD[0]};
`endif

  assign evt_raw = press | rpt_hit;
  assign pop     = !fifo_empty && evt_ready;

  // Round-robin grant starting at rr_q; a grant and a new event on the same key
  // in one cycle act as clear-then-set, so only a press on a still-pending key is dropped.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    idx       = 0;
    idx_w     = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= N_KEYS) begin
        idx = idx - N_KEYS;
      end
      idx_w = KW'(idx);
      if (!grant_vld && pending_q[idx_w] && (!fifo_full || pop)) begin
        grant_vld       = 1'b1;
        grant_idx       = idx_w;
        grant_oh[idx_w] = 1'b1;
      end
    end
    rr_d = rr_q;
    if (grant_vld) begin
      rr_d = (grant_idx == KW'(N_KEYS - 1)) ? '0 : grant_idx + 1'b1;
    end
    pending_d = (pending_q & ~grant_oh) | evt_raw;
    ovf_d     = ovf_q || (|(evt_raw & pending_q & ~grant_oh));
  end

  // Synchronizer, debounce, pending, round-robin and overflow registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      stable_q  <= '0;
      prev_q    <= '0;
      pending_q <= '0;
      rr_q      <= '0;
      ovf_q     <= 1'b0;
      for (int k = 0; k < N_KEYS; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      stable_q  <= stable_d;
      prev_q    <= prev_d;
      pending_q <= pending_d;
      rr_q      <= rr_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
    end
  end

  key_event_fifo #(
    .W     (KW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (CLK),
    .rst_n    (RST),
    .push_vld (grant_vld),
    .push_dat (grant_idx),
    .pop_rdy  (evt_ready),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head_dat (head_code)
  );

  assign evt_valid    = !fifo_empty;
  assign evt_code     = evt_valid ? head_code : '0;
  assign key_state    = stable_q;
  assign evt_overflow = ovf_q;
endmodule
